decimator_mc: RTL

- Multi-channel, runtime-programmable decimator for the CIC/SDR receive chain.
- Accepts TDM-interleaved samples from CH channels and decimates each channel by a runtime rate R (1..RMAX).
- Two modes: pick (keep one sample in R) and sum (accumulate-and-dump, a 1-stage boxcar).
- Output side uses a valid/ready handshake with overrun detection, so it can feed the next filter stage or a FIFO directly.

---
 rtl/decimator_mc_if.sv | 33 +++
 rtl/decimator_mc.sv | 91 +++++++++
 2 files changed

// File: rtl/decimator_mc_if.sv
// Sample-side and result-side signals of the multi-channel decimator.
// The master modport belongs to whatever feeds samples and drains results.
interface decimator_mc_if #(
  parameter int W    = 16,
  parameter int CH   = 2,
  parameter int RMAX = 64
);
  localparam int RW = $clog2(RMAX + 1);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int OW = W + $clog2(RMAX);

  logic                 i_ce;
  logic                 i_sof;
  logic signed [W-1:0]  i_data;
  logic [RW-1:0]        i_rate;
  logic                 i_mode;
  logic                 i_ready;
  logic signed [OW-1:0] o_data;
  logic [CW-1:0]        o_chan;
  logic                 o_valid;
  logic                 o_overrun;
  logic                 o_sync_err;

  modport master (
    output i_ce, i_sof, i_data, i_rate, i_mode, i_ready,
    input  o_data, o_chan, o_valid, o_overrun, o_sync_err
  );

  modport slave (
    input  i_ce, i_sof, i_data, i_rate, i_mode, i_ready,
    output o_data, o_chan, o_valid, o_overrun, o_sync_err
  );
endinterface

// File: rtl/decimator_mc.sv
// TDM multi-channel decimator: pick (keep last of R) or sum (boxcar of R) per channel,
// with a held valid/ready result register and sticky overrun flag.
module decimator_mc #(
  parameter int W    = 16,
  parameter int CH   = 2,
  parameter int RMAX = 64
) (
  input logic           i_clk,
  input logic           i_reset,
  decimator_mc_if.slave bus
);
  localparam int RW = $clog2(RMAX + 1);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int OW = W + $clog2(RMAX);

  logic [CW-1:0]        ch, cur_ch, next_ch;
  logic [RW-1:0]        fc, cur_fc, r_lat, r_eff, r_use;
  logic                 mode_lat, mode_use;
  logic                 resync, group_start, complete, ch_last, load;
  logic signed [OW-1:0] acc [CH];
  logic signed [OW-1:0] sext, acc_in, result;

  // A sof at a nonzero slot restarts the frame and group at this very sample.
  always_comb begin
    if (bus.i_rate <= RW'(1))
      r_eff = RW'(1);
    else if (bus.i_rate > RW'(RMAX))
      r_eff = RW'(RMAX);
    else
      r_eff = bus.i_rate;

    resync      = bus.i_sof && (ch != '0);
    cur_ch      = bus.i_sof ? '0 : ch;
    cur_fc      = resync ? '0 : fc;
    group_start = (cur_fc == '0) && (cur_ch == '0);
    r_use       = group_start ? r_eff : r_lat;
    mode_use    = group_start ? bus.i_mode : mode_lat;

    sext     = {{(OW-W){bus.i_data[W-1]}}, bus.i_data};
    acc_in   = (cur_fc == '0) ? sext : acc[cur_ch] + sext;
    complete = (cur_fc == r_use - RW'(1));
    result   = mode_use ? acc_in : sext;
    ch_last  = (cur_ch == CW'(CH - 1));
    next_ch  = ch_last ? '0 : cur_ch + CW'(1);
    load     = bus.i_ce && complete;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ch             <= '0;
      fc             <= '0;
      r_lat          <= RW'(1);
      mode_lat       <= 1'b0;
      for (int i = 0; i < CH; i++) acc[i] <= '0;
      bus.o_data     <= '0;
      bus.o_chan     <= '0;
      bus.o_valid    <= 1'b0;
      bus.o_overrun  <= 1'b0;
      bus.o_sync_err <= 1'b0;
    end else begin
      bus.o_sync_err <= bus.i_ce && resync;

      if (bus.i_ce) begin
        ch <= next_ch;
        if (ch_last)
          fc <= complete ? '0 : cur_fc + RW'(1);
        else
          fc <= cur_fc;
        if (group_start) begin
          r_lat    <= r_eff;
          mode_lat <= bus.i_mode;
        end
        if (resync)
          for (int i = 0; i < CH; i++) acc[i] <= '0;
        acc[cur_ch] <= acc_in;
      end

      // A result arriving while the held one is blocked is dropped, not queued.
      if (load && (!bus.o_valid || bus.i_ready)) begin
        bus.o_data  <= result;
        bus.o_chan  <= cur_ch;
        bus.o_valid <= 1'b1;
      end else if (bus.o_valid && bus.i_ready) begin
        bus.o_valid <= 1'b0;
      end

      if (load && bus.o_valid && !bus.i_ready)
        bus.o_overrun <= 1'b1;
    end
  end
endmodule
